// File: rtl/seq_gen_if.sv
// seq_gen_if: control and serial-output bundle for the seq_gen pattern transmitter.
//   master: the controller side. It drives start, pattern_i, repeat_i, gap_i and abort,
//           and it receives the serial line and the status signals.
//   slave : the seq_gen side. It receives the request fields and drives
//           out, out_valid, frame_start, busy and done.
interface seq_gen_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
);
  logic             start;
  logic [PAT_W-1:0] pattern_i;
  logic [CNT_W-1:0] repeat_i;
  logic [GAP_W-1:0] gap_i;
  logic             abort;
  logic             out;
  logic             out_valid;
  logic             frame_start;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern_i, repeat_i, gap_i, abort,
    input  out, out_valid, frame_start, busy, done
  );

  modport slave (
    input  start, pattern_i, repeat_i, gap_i, abort,
    output out, out_valid, frame_start, busy, done
  );
endinterface

// File: rtl/seq_gen.sv
// seq_gen: serial pattern transmitter. It sends a PAT_W-bit pattern MSB-first,
// one bit per clock, and repeats it R = max(repeat_i,1) times. Each repetition
// after the first is preceded by gap_i idle zero bits.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   bus - seq_gen_if.slave. It carries these signals:
//         inputs : start, pattern_i, repeat_i, gap_i, abort
//         outputs: out, out_valid, frame_start, busy, done
// Every output is registered. The next-output values are produced together
// with the next state.
module seq_gen #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input logic    clk,
  input logic    rst,
  seq_gen_if.slave bus
);

  localparam int BC_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(PAT_W - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t           state, state_n;
  logic [PAT_W-1:0] shreg, shreg_n;     // bits of the current frame still to be sent
  logic [PAT_W-1:0] pat_lat, pat_lat_n;
  logic [GAP_W-1:0] gap_lat, gap_lat_n;
  logic [BC_W-1:0]  bit_cnt, bit_cnt_n; // index of the bit currently on out
  logic [CNT_W-1:0] rep_cnt, rep_cnt_n; // repetitions left, including the current one
  logic [GAP_W-1:0] gap_cnt, gap_cnt_n; // gap cycles left, including the current one

  logic out_r, out_n;
  logic vld_r, vld_n;
  logic fs_r, fs_n;
  logic busy_r, busy_n;
  logic done_r, done_n;

  // Set on any cycle whose next output is the MSB of a new frame.
  logic             reload;
  logic [PAT_W-1:0] pat_src;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      pat_lat <= '0;
      gap_lat <= '0;
      bit_cnt <= '0;
      rep_cnt <= '0;
      gap_cnt <= '0;
      out_r   <= 1'b0;
      vld_r   <= 1'b0;
      fs_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      pat_lat <= pat_lat_n;
      gap_lat <= gap_lat_n;
      bit_cnt <= bit_cnt_n;
      rep_cnt <= rep_cnt_n;
      gap_cnt <= gap_cnt_n;
      out_r   <= out_n;
      vld_r   <= vld_n;
      fs_r    <= fs_n;
      busy_r  <= busy_n;
      done_r  <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    pat_lat_n = pat_lat;
    gap_lat_n = gap_lat;
    bit_cnt_n = bit_cnt;
    rep_cnt_n = rep_cnt;
    gap_cnt_n = gap_cnt;
    out_n     = 1'b0;
    vld_n     = 1'b0;
    fs_n      = 1'b0;
    busy_n    = 1'b0;
    done_n    = 1'b0;
    reload    = 1'b0;
    pat_src   = pat_lat;

    case (state)
      IDLE: begin
        // When abort and start arrive together, abort wins and the start is dropped.
        if (bus.start && !bus.abort) begin
          state_n   = SEND;
          pat_lat_n = bus.pattern_i;
          gap_lat_n = bus.gap_i;
          rep_cnt_n = (bus.repeat_i == '0) ? CNT_W'(1) : bus.repeat_i;
          pat_src   = bus.pattern_i;
          reload    = 1'b1;
        end
      end

      SEND: begin
        if (bus.abort) begin
          state_n = IDLE;
        end else if (bit_cnt == LAST_BIT) begin
          rep_cnt_n = rep_cnt - CNT_W'(1);
          if (rep_cnt == CNT_W'(1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else if (gap_lat != '0) begin
            state_n   = GAP;
            gap_cnt_n = gap_lat;
            busy_n    = 1'b1;
          end else begin
            reload = 1'b1;
          end
        end else begin
          out_n     = shreg[PAT_W-1];
          shreg_n   = {shreg[PAT_W-2:0], 1'b0};
          bit_cnt_n = bit_cnt + BC_W'(1);
          vld_n     = 1'b1;
          busy_n    = 1'b1;
        end
      end

      GAP: begin
        if (bus.abort) begin
          state_n = IDLE;
        end else if (gap_cnt == GAP_W'(1)) begin
          state_n = SEND;
          reload  = 1'b1;
        end else begin
          gap_cnt_n = gap_cnt - GAP_W'(1);
          busy_n    = 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase

    // Start a frame. The MSB goes straight to out, and the remaining bits are queued.
    if (reload) begin
      out_n     = pat_src[PAT_W-1];
      shreg_n   = {pat_src[PAT_W-2:0], 1'b0};
      bit_cnt_n = '0;
      vld_n     = 1'b1;
      fs_n      = 1'b1;
      busy_n    = 1'b1;
    end
  end

  assign bus.out         = out_r;
  assign bus.out_valid   = vld_r;
  assign bus.frame_start = fs_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;

endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: directed testbench for seq_gen with PAT_W=4, CNT_W=8, GAP_W=4.
// It contains three kinds of check:
//   - a cycle-by-cycle table of inputs and expected {out,out_valid,frame_start,busy,done}
//   - hand-written transfers that count busy cycles, frame starts, done pulses and 1101 hits
//   - a mid-gap asynchronous reset
module tb_seq_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  seq_gen_if #(.PAT_W(4), .CNT_W(8), .GAP_W(4)) bus ();

  seq_gen #(.PAT_W(4), .CNT_W(8), .GAP_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       st;
    logic [3:0] pat;
    logic [7:0] rep;
    logic [3:0] gap;
    logic       ab;
    logic [4:0] exp;  // {out, out_valid, frame_start, busy, done}
  } vec_t;

  vec_t vq[$];

  localparam logic [4:0] E_MSB  = 5'b11110;
  localparam logic [4:0] E_ONE  = 5'b11010;
  localparam logic [4:0] E_ZERO = 5'b01010;
  localparam logic [4:0] E_GAP  = 5'b00010;
  localparam logic [4:0] E_DONE = 5'b00001;
  localparam logic [4:0] E_IDLE = 5'b00000;

  function automatic void add(input logic st, input logic [3:0] pat, input logic [7:0] rep,
                              input logic [3:0] gap, input logic ab, input logic [4:0] exp);
    vec_t v;
    v.st = st; v.pat = pat; v.rep = rep; v.gap = gap; v.ab = ab; v.exp = exp;
    vq.push_back(v);
  endfunction

  // Junk request values are applied while no start is given. A transfer in
  // progress must ignore them.
  function automatic void step(input logic [4:0] exp);
    add(1'b0, 4'b0010, 8'd7, 4'd9, 1'b0, exp);
  endfunction

  task automatic check(input string nm, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  function automatic logic [4:0] outs();
    return {bus.out, bus.out_valid, bus.frame_start, bus.busy, bus.done};
  endfunction

  // Run one transfer and tally its observable effects.
  task automatic measure(input string nm, input logic [3:0] pat, input logic [7:0] rep,
                         input logic [3:0] gap, input int exp_busy, input int exp_fs,
                         input int exp_hits);
    int nb = 0;
    int nf = 0;
    int nd = 0;
    int nh = 0;
    logic [3:0] hist = 4'b0000;
    bit seen = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.pattern_i = pat; bus.repeat_i = rep; bus.gap_i = gap;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.busy) nb++;
      if (bus.frame_start) nf++;
      if (bus.done) begin nd++; seen = 1'b1; end
      if (bus.out_valid) begin
        hist = {hist[2:0], bus.out};
        if (hist == 4'b1101) nh++;
      end
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (bus.done) nd++;
      if (bus.busy) nb++;
    end
    check({nm, " done_count"}, nd, 1);
    check({nm, " busy_cycles"}, nb, exp_busy);
    check({nm, " frame_starts"}, nf, exp_fs);
    check({nm, " hits_1101"}, nh, exp_hits);
  endtask

  initial begin
    bus.start = 1'b0; bus.pattern_i = '0; bus.repeat_i = '0; bus.gap_i = '0; bus.abort = 1'b0;

    // A: 1101 sent once with no gap. The next start lands in the done cycle.
    add(1'b1, 4'b1101, 8'd1, 4'd0, 1'b0, E_MSB);
    step(E_ONE); step(E_ZERO); step(E_ONE); step(E_DONE);
    // B: 1101 sent three times back to back.
    add(1'b1, 4'b1101, 8'd3, 4'd0, 1'b0, E_MSB);
    step(E_ONE); step(E_ZERO); step(E_ONE);
    step(E_MSB); step(E_ONE); step(E_ZERO); step(E_ONE);
    step(E_MSB); step(E_ONE); step(E_ZERO); step(E_ONE);
    step(E_DONE); step(E_IDLE);
    // C: 1101 sent twice with a three-cycle gap.
    add(1'b1, 4'b1101, 8'd2, 4'd3, 1'b0, E_MSB);
    step(E_ONE); step(E_ZERO); step(E_ONE);
    step(E_GAP); step(E_GAP); step(E_GAP);
    step(E_MSB); step(E_ONE); step(E_ZERO); step(E_ONE);
    step(E_DONE); step(E_IDLE);
    // D: repeat 0 acts as 1. A start during busy must not re-latch the request.
    add(1'b1, 4'b1011, 8'd0, 4'd0, 1'b0, E_MSB);
    add(1'b1, 4'b0100, 8'd5, 4'd2, 1'b0, E_ZERO);
    step(E_ONE); step(E_ONE); step(E_DONE); step(E_IDLE);
    // E: abort on the second bit of the second repetition, then a fresh 1001 frame.
    add(1'b1, 4'b1101, 8'd2, 4'd1, 1'b0, E_MSB);
    step(E_ONE); step(E_ZERO); step(E_ONE); step(E_GAP);
    step(E_MSB); step(E_ONE);
    add(1'b0, 4'b0010, 8'd7, 4'd9, 1'b1, E_IDLE);
    add(1'b1, 4'b1001, 8'd1, 4'd0, 1'b0, E_MSB);
    step(E_ZERO); step(E_ZERO); step(E_ONE); step(E_DONE);
    // F: start and abort together in IDLE, so the start is dropped. An abort alone in IDLE has no effect.
    add(1'b1, 4'b1101, 8'd9, 4'd9, 1'b1, E_IDLE);
    add(1'b0, 4'b0000, 8'd0, 4'd0, 1'b1, E_IDLE);
    step(E_IDLE);
    // G: abort during GAP.
    add(1'b1, 4'b1101, 8'd2, 4'd2, 1'b0, E_MSB);
    step(E_ONE); step(E_ZERO); step(E_ONE); step(E_GAP);
    add(1'b0, 4'b0010, 8'd7, 4'd9, 1'b1, E_IDLE);
    step(E_IDLE);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", int'(outs()), 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vq[i]) begin
      @(negedge clk);
      bus.start = vq[i].st; bus.pattern_i = vq[i].pat; bus.repeat_i = vq[i].rep;
      bus.gap_i = vq[i].gap; bus.abort = vq[i].ab;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), int'(outs()), int'(vq[i].exp));
    end
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;

    measure("r3g0", 4'b1101, 8'd3, 4'd0, 12, 3, 3);
    measure("r2g3", 4'b1101, 8'd2, 4'd3, 11, 2, 2);
    measure("r0",   4'b1011, 8'd0, 4'd0, 4, 1, 0);

    // Assert reset in the middle of a gap.
    @(negedge clk);
    bus.start = 1'b1; bus.pattern_i = 4'b1101; bus.repeat_i = 8'd2; bus.gap_i = 4'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("in_gap_state", int'(outs()), int'(E_GAP));
    #2 rst = 1'b1;
    #1;
    check("async_reset_outputs", int'(outs()), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check($sformatf("post_reset_idle%0d", c), int'(outs()), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
